// File: rtl/down_counter_timer_if.sv
// Control inputs and status outputs of the down-counter timer, bundled for port connection.
// The master drives the controls; the slave (the timer) drives Q/busy/tc/done.
interface down_counter_timer_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             hold;
  logic             auto_reload;
  logic [WIDTH-1:0] Q;
  logic             busy;
  logic             tc;
  logic             done;

  modport master (
    output load, load_val, start, hold, auto_reload,
    input  Q, busy, tc, done
  );

  modport slave (
    input  load, load_val, start, hold, auto_reload,
    output Q, busy, tc, done
  );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable down-counter timer: IDLE/RUN/DONE FSM, one-cycle terminal-count pulse, optional auto-reload.
// Single-cycle response to every control; no backpressure (controls are sampled every clk edge).
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 clear,
  down_counter_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q  <= IDLE;
      q_q      <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // Priority: load > start > count/hold. tc only ever rises on the terminal-count edge.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (bus.load) begin
      reload_d = bus.load_val;
      q_d      = bus.load_val;
      state_d  = IDLE;
    end else if (bus.start && (state_q != RUN)) begin
      q_d     = reload_q;
      state_d = RUN;
    end else if ((state_q == RUN) && !bus.hold) begin
      if (q_q == '0) begin
        tc_d = 1'b1;
        if (bus.auto_reload) begin
          q_d = reload_q;
        end else begin
          state_d = DONE;
        end
      end else begin
        q_d = q_q - 1'b1;
      end
    end
  end

  assign bus.Q    = q_q;
  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.tc   = tc_q;

endmodule

// File: doc/down_counter_timer.md
DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning counter and load-value width in bits (WIDTH >= 2).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port clear  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port load  input  1  capture load_val into reload register and count.
REQ-005 SHALL have port load_val  input  WIDTH  reload/start value.
REQ-006 SHALL have port start  input  1  begin a count from the reload register.
REQ-007 SHALL have port hold  input  1  freeze count while running.
REQ-008 SHALL have port auto_reload  input  1  1 = restart from reload value on terminal count; 0 = stop.
REQ-009 SHALL have port Q  output  WIDTH  current count, registered.
REQ-010 SHALL have port busy  output  1  high while in RUN, registered.
REQ-011 SHALL have port tc  output  1  one-cycle terminal-count pulse, registered.
REQ-012 SHALL have port done  output  1  level, high while in DONE, registered.

Function
REQ-013 SHALL implement a 3-state FSM: IDLE, RUN, DONE. busy = (state == RUN); done = (state == DONE).
REQ-014 SHALL hold an internal WIDTH-bit reload register, written only by load.
REQ-015 Priority per edge SHALL be: clear low > load > start > count/hold.
REQ-016 load=1, any state: reload register <= load_val, Q <= load_val, state <= IDLE, tc <= 0.
REQ-017 start=1, load=0, state IDLE or DONE: Q <= reload register, state <= RUN, tc <= 0.
REQ-018 start in RUN SHALL be ignored.
REQ-019 RUN, hold=1: Q, state and reload register unchanged; tc <= 0.
REQ-020 RUN, hold=0, Q != 0: Q <= Q - 1, tc <= 0.
REQ-021 RUN, hold=0, Q == 0, auto_reload=1: tc <= 1, Q <= reload register, state stays RUN.
REQ-022 RUN, hold=0, Q == 0, auto_reload=0: tc <= 1, Q stays 0, state <= DONE.
REQ-023 Reload value N SHALL give a period of N+1 cycles (Q = N..0), with tc asserted in the cycle after Q = 0.
REQ-024 Reload value 0 with auto_reload=1 SHALL assert tc every cycle while running and not held.
REQ-025 tc SHALL never be high for two consecutive cycles unless REQ-024 applies.
REQ-026 auto_reload SHALL be sampled only at the terminal-count edge; changing it mid-count takes effect at the next terminal count.
REQ-027 Q SHALL never wrap from 0 to all-ones.
REQ-028 IDLE and DONE with no load/start: all registers unchanged; tc <= 0.

Reset
REQ-029 clear=0 at a rising clk edge SHALL set Q=0, reload register=0, state=IDLE, busy=0, tc=0, done=0, overriding load, start and hold.
REQ-030 clear SHALL have no effect between clock edges; outputs change only at clk edges.
REQ-031 clear deasserted mid-operation SHALL leave the block in IDLE; it does not resume the interrupted count.

Verification
REQ-032 Reset mid-count: WIDTH=4, running at Q=6, clear=0 for 2 cycles -> after first edge Q=0, busy=0, done=0, tc=0; stays so until start.
REQ-033 Single shot: load_val=5, load 1 cycle, then start 1 cycle, auto_reload=0 -> Q = 5,4,3,2,1,0 on consecutive edges, busy=1 throughout; next edge tc=1 for exactly 1 cycle, done=1, busy=0, Q=0.
REQ-034 Auto-reload: load_val=2, start, auto_reload=1 -> Q = 2,1,0,2,1,0,...; tc=1 in each cycle where Q returns to 2 after 0, period 3 cycles.
REQ-035 Hold: running at Q=3, hold=1 for 3 cycles -> Q=3, busy=1, tc=0 for those cycles; then counts 2,1,0.
REQ-036 Load overrides: in RUN at Q=2, load=1 and start=1 same edge, load_val=9 -> Q=9, state IDLE, busy=0; next start -> count from 9.
REQ-037 Zero reload: load_val=0, start, auto_reload=0 -> next edge Q=0, busy=1; following edge tc=1, done=1, busy=0.
